// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the 5-stage MIPS pipeline.
// A 3-entry scoreboard (EX/MEM/WB) tracks pending register writes. It detects
// load-use hazards, resolves taken branches and jumps, and counts data-hazard
// bubbles in a saturating counter. State advances on the falling clock edge.
// Optional build macro HAZARD_NO_FORWARD_EN: the datapath has no forwarding, so
// any producer still in EX or MEM stalls a dependent consumer in ID.
module pipe_hazard_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_jump,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_stall,
    output logic [CNT_WIDTH-1:0]  bubble_count
);

    typedef struct packed {
        logic                  valid;
        logic                  load;
        logic [REG_ADDR_W-1:0] addr;
    } sb_entry_t;

    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;
    sb_entry_t insert;
    logic      data_hazard;

    // Register 0 is hard-wired to zero and never creates a dependency.
    function automatic logic match(input sb_entry_t e);
        logic hit_rs;
        logic hit_rt;
        hit_rs = id_use_rs && (e.addr == id_rs);
        hit_rt = id_use_rt && (e.addr == id_rt);
        return e.valid && (e.addr != '0) && (hit_rs || hit_rt);
    endfunction

    // Entry pushed into EX: a bubble (stall or flush) carries no pending write.
    always_comb begin
        insert.valid = id_regwrite & ~idex_stall;
        insert.load  = id_memread;
        insert.addr  = id_dest;
    end

    // Hazard detection: load-use only, or any EX/MEM producer without forwarding.
    always_comb begin
`ifdef HAZARD_NO_FORWARD_EN
        data_hazard = match(sb_ex) | match(sb_mem);
`else
        data_hazard = sb_ex.load & match(sb_ex);
`endif
    end

    // Front-end and ID/EX control, branch > data hazard > jump > normal.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_stall = 1'b1;
        end else if (data_hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_stall = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // Scoreboard shift register, advancing one stage per falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= insert;
        end
    end

    // Saturating count of data-hazard bubbles; branch flushes are not counted.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count <= '0;
        end else if (data_hazard && !ex_branch_taken && (bubble_count != '1)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Generates the stall (bubble) control consumed by the ID/EX pipeline register, plus PC-write, IF/ID-write and IF/ID-flush controls for the front end.
- Keeps an internal 3-entry scoreboard (EX/MEM/WB) of pending register writes. It detects load-use hazards, resolves taken branches and jumps, and counts bubble cycles.

Parameters:
- CNT_WIDTH, 16, width of the saturating bubble-cycle counter.
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dest  in  REG_ADDR_W  write-back address decoded in ID.
- id_regwrite  in  1  ID instruction writes a register.
- id_memread  in  1  ID instruction is a load.
- id_jump  in  1  ID instruction is a jump.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_stall  out  1  ID/EX loads a bubble (all zeros).
- bubble_count  out  CNT_WIDTH  saturating count of data-hazard bubbles.

Behaviour:
- Scoreboard entry format: {valid, load, addr}.
  - Entries sb_ex, sb_mem and sb_wb update every falling clk edge:
    - sb_wb <= sb_mem
    - sb_mem <= sb_ex
    - sb_ex <= insert
  - insert = {id_regwrite & ~idex_stall, id_memread, id_dest}; valid is forced to 0 when idex_stall=1.
- match(e), evaluated combinationally:
  - true when e.valid & e.addr!=0 & ((id_use_rs & e.addr==id_rs) | (id_use_rt & e.addr==id_rt)).
  - Register 0 never causes a hazard.
- data_hazard = sb_ex.load & match(sb_ex). A load-use hazard therefore produces exactly 1 bubble: next cycle the load sits in sb_mem.
- Output decode is combinational from scoreboard state and inputs. Priority, highest first:
  - ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_stall=1. This kills the ID and IF instructions; the pending hazard is discarded.
  - data_hazard: pc_write=0, ifid_write=0, ifid_flush=0, idex_stall=1. PC and IF/ID hold; the bubble enters EX.
  - id_jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_stall=0. The jump proceeds; its fall-through instruction is killed.
  - otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_stall=0.
- bubble_count:
  - Increments on each falling edge where data_hazard=1 and ex_branch_taken=0.
  - Saturates at all-ones and never wraps.
  - Branch flushes are not counted.
- Reset, asynchronous on the falling edge of reset:
  - All scoreboard entries are cleared (valid=0); bubble_count=0.
  - While reset=0, outputs read pc_write=1, ifid_write=1, ifid_flush=0, idex_stall=0, provided ex_branch_taken and id_jump are low.
  - Reset asserted mid-stall cancels the stall immediately.
- Back-to-back hazards: a load followed by a dependent load followed by a dependent use gives 1 bubble per dependency, 2 bubbles total.

Optional Feature:
- Macro: HAZARD_NO_FORWARD_EN.
- Defined: the datapath has no forwarding.
  - data_hazard = match(sb_ex) | match(sb_mem), regardless of load.
  - WB is written first half-cycle and is never a hazard.
  - An ALU producer followed immediately by a dependent consumer gives 2 bubbles; with one unrelated instruction between them, 1 bubble.
- Undefined: load-use detection only, as described in Behaviour.

Test Plan:
- Reset hold: reset=0 with random inputs, then release → scoreboard empty, bubble_count=0, no stall on first instruction.
- Load-use: lw $8 in ID, then add with id_rs=8, id_use_rs=1 → exactly 1 cycle of idex_stall=1, pc_write=0, ifid_write=0; bubble_count 0→1.
- Register zero: lw $0 followed by a use of $0 → no stall.
- Branch priority: ex_branch_taken=1 in the same cycle a load-use hazard is present → ifid_flush=1, idex_stall=1, pc_write=1; bubble_count unchanged; inserted entry invalid.
- Jump: id_jump=1, no hazard → ifid_flush=1 for 1 cycle, idex_stall=0.
- Saturation: CNT_WIDTH=4, 20 load-use pairs → bubble_count stops at 15. With HAZARD_NO_FORWARD_EN defined, add $9 followed by sub reading $9 → 2 bubbles.
